// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending controller, the coin
// hopper and the change dispenser.
interface change_dispenser_if;
    logic       start;
    logic [8:0] amount;
    logic       restock;
    logic       hopper_ready;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] remaining;
    logic [6:0] n_nickel;
    logic [6:0] n_dime;
    logic [6:0] n_quarter;
    logic [6:0] n_dollar;
    logic [3:0] empty;

    modport master (
        output start, amount, restock, hopper_ready,
        input  coin_valid, coin_sel, busy, done, err, remaining,
        input  n_nickel, n_dime, n_quarter, n_dollar, empty
    );

    modport slave (
        input  start, amount, restock, hopper_ready,
        output coin_valid, coin_sel, busy, done, err, remaining,
        output n_nickel, n_dime, n_quarter, n_dollar, empty
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change payout engine: pays out a cent amount one coin at a
// time through a valid/ready handshake, limited by per-coin inventory.
module change_dispenser #(
    parameter int unsigned INIT_NICKEL  = 20,
    parameter int unsigned INIT_DIME    = 20,
    parameter int unsigned INIT_QUARTER = 20,
    parameter int unsigned INIT_DOLLAR  = 10
) (
    input  logic              clk,
    input  logic              cancelReset,
    change_dispenser_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index 0 is the nickel, matching the coin_sel encoding.
    localparam logic [3:0][7:0] INIT_INV = {
        8'(INIT_DOLLAR), 8'(INIT_QUARTER), 8'(INIT_DIME), 8'(INIT_NICKEL)
    };

    state_t          state_q;
    logic            coinValid_q;
    logic [1:0]      coinSel_q;
    logic            done_q;
    logic            err_q;
    logic [8:0]      remaining_q;
    logic [3:0][6:0] count_q;
    logic [3:0][7:0] inv_q;

    logic            pickFound_d;
    logic [1:0]      pickSel_d;
    logic            amountLegal;
    logic [3:0]      empty_d;

    function automatic logic [8:0] coinValue(input logic [1:0] sel);
        case (sel)
            2'd0:    coinValue = 9'd5;
            2'd1:    coinValue = 9'd10;
            2'd2:    coinValue = 9'd25;
            default: coinValue = 9'd100;
        endcase
    endfunction

    assign amountLegal = (bus.amount <= 9'd500) && ((bus.amount % 9'd5) == 9'd0);

    // Pick the largest coin that fits the amount still owed and is in stock;
    // scanning upward lets the last match win.
    always_comb begin
        pickFound_d = 1'b0;
        pickSel_d   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if ((inv_q[i] != 8'd0) && (coinValue(2'(i)) <= remaining_q)) begin
                pickFound_d = 1'b1;
                pickSel_d   = 2'(i);
            end
        end
    end

    // Flag each denomination whose inventory has run out.
    always_comb begin
        empty_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            empty_d[i] = (inv_q[i] == 8'd0);
        end
    end

    // Payout state machine with all outputs registered; an abort drops the
    // in-flight coin without counting it and reloads the inventory.
    always_ff @(posedge clk or posedge cancelReset) begin
        if (cancelReset) begin
            state_q     <= IDLE;
            coinValid_q <= 1'b0;
            coinSel_q   <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= 9'd0;
            count_q     <= '0;
            inv_q       <= INIT_INV;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.restock) begin
                        inv_q <= INIT_INV;
                    end
                    if (bus.start) begin
                        if (amountLegal) begin
                            remaining_q <= bus.amount;
                            count_q     <= '0;
                            err_q       <= 1'b0;
                            state_q     <= SELECT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (remaining_q == 9'd0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (pickFound_d) begin
                        coinSel_q   <= pickSel_d;
                        coinValid_q <= 1'b1;
                        state_q     <= EJECT;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                EJECT: begin
                    if (coinValid_q && bus.hopper_ready) begin
                        remaining_q         <= remaining_q - coinValue(coinSel_q);
                        inv_q[coinSel_q]    <= inv_q[coinSel_q] - 8'd1;
                        count_q[coinSel_q]  <= count_q[coinSel_q] + 7'd1;
                        coinValid_q         <= 1'b0;
                        state_q             <= SELECT;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.coin_valid = coinValid_q;
    assign bus.coin_sel   = coinSel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.remaining  = remaining_q;
    assign bus.n_nickel   = count_q[0];
    assign bus.n_dime     = count_q[1];
    assign bus.n_quarter  = count_q[2];
    assign bus.n_dollar   = count_q[3];
    assign bus.empty      = empty_d;

endmodule
